reg_invert_bank: RTL and testbench
==================================

Name: reg_invert_bank

Overview:
Parametrised, registered successor to the fixed 8-bit combinational inverter bank. It synchronises an input bus and drives a registered output bus in one of four modes: invert, pass, rising-edge toggle, or rotate. It adds load, hold and change-detect behaviour. It sits directly between a tile's io_in and io_out pins.

Parameters:
WIDTH, 8, data bus width (>=1)
SYNC_STAGES, 2, input synchroniser depth (>=1)
RESET_VAL, {WIDTH{1'b1}}, dout value on reset (matches inverted all-zero input)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
io_in  input  WIDTH  asynchronous data input bus
mode  input  2  00 INVERT, 01 PASS, 10 TOGGLE, 11 ROTATE; sampled each edge, not synchronised
en  input  1  update enable; 0 = hold dout
load  input  1  force dout <= din_s, overrides en and mode
io_out  output  WIDTH  registered result (dout)
changed  output  1  high for exactly the cycles in which io_out holds a value different from its previous cycle

Behaviour:
- Reset: rst_n low asynchronously sets the following, independent of clk:
  - all synchroniser stages = 0
  - edge-history register din_p = 0
  - dout = RESET_VAL
  - changed = 0
- Reset release is synchronous to clk in effect: the first update occurs at the first rising edge with rst_n high.
- Reset mid-operation discards in-flight synchroniser data. No partial state survives.
- Synchroniser: din_s = last stage of a SYNC_STAGES-deep flop chain on io_in. din_p <= din_s every edge, regardless of en, load or mode.
- Update priority, evaluated at each rising edge:
  1. load=1: dout <= din_s.
  2. else en=0: dout holds.
  3. else by mode:
     - INVERT: dout <= ~din_s
     - PASS: dout <= din_s
     - TOGGLE: dout <= dout ^ (din_s & ~din_p). Each bit flips once per synchronised rising edge. Falling edges and held-high levels have no effect.
     - ROTATE: dout <= {dout[WIDTH-2:0], dout[WIDTH-1]}. When WIDTH=1 this holds the value.
- Latency: an io_in change appears on io_out SYNC_STAGES+1 edges later in INVERT/PASS/load.
- TOGGLE edge detection lags io_in by SYNC_STAGES edges, and the toggle lands one edge after that.
- changed: registered together with dout as |(dout_next ^ dout).
  - Asserted in the same cycle the new io_out value is visible.
  - Deasserted on hold, or when an update produces an identical value (e.g. PASS of a static input, ROTATE of all-ones).
- Mode switch takes effect at the next edge, with no pipeline flush. Switching into TOGGLE uses the current din_p, so no spurious toggle occurs for levels that are already high.
- load and en both high: load wins. load with en=0 still loads.
- din_p keeps tracking while en=0, so re-enabling TOGGLE does not replay edges that occurred during the hold.
- The design is fully synchronous apart from rst_n. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset/latency:
  - Stimulus: rst_n=0 with io_in=8'h00, then release; mode=INVERT, en=1; at cycle 5 drive io_in=8'hA5.
  - Required: io_out=8'hFF and changed=0 during reset; io_out=8'h5A exactly 3 edges after the io_in change; changed=1 for that single cycle only.
- PASS + hold:
  - Stimulus: mode=PASS, io_in=8'h3C until stable; set en=0; change io_in to 8'hC3.
  - Required: io_out stays 8'h3C and changed stays 0; after en=1, io_out=8'hC3 within 3 edges.
- TOGGLE:
  - Stimulus: start from io_out=8'h00 (via load); mode=TOGGLE; pulse io_in[0] high for 4 cycles, low for 4, twice.
  - Required: io_out[0] goes 0->1->0, one flip per rising edge; the other bits stay 0; holding io_in[0] high causes no further flips.
- ROTATE:
  - Stimulus: load 8'h81; mode=ROTATE, en=1 for 8 edges.
  - Required: sequence 03,06,0C,18,30,60,C0,81; changed=1 each cycle. Loading 8'hFF then rotating gives changed=0.
- Priority + async reset:
  - Stimulus: load=1, en=1, mode=ROTATE with din_s=8'h12.
  - Required: io_out=8'h12.
  - Stimulus: assert rst_n=0 mid-cycle.
  - Required: io_out=8'hFF immediately, without a clock edge.
- Parametrisation:
  - Stimulus: WIDTH=1, SYNC_STAGES=1 build; repeat the INVERT and ROTATE checks.
  - Required: INVERT latency is 2 edges; ROTATE holds the value and changed=0.

Source files
------------

// File: rtl/reg_invert_bank.sv
// reg_invert_bank: registered, parametrised inverter bank between a tile's
// io_in and io_out pins. The input bus is synchronised first. The output
// register is then updated in one of four modes: invert, pass, rising-edge
// toggle or rotate. A load forces the synchronised input onto the output,
// en=0 holds the output, and changed flags every cycle in which io_out differs
// from its previous value.

module reg_invert_bank #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] io_in,
   input  logic [1:0]       mode,
   input  logic             en,
   input  logic             load,
   output logic [WIDTH-1:0] io_out,
   output logic             changed
);

   // The mode encoding matches the pin-level encoding, so a plain cast is enough.
   typedef enum logic [1:0] {
      MODE_INVERT = 2'b00,
      MODE_PASS   = 2'b01,
      MODE_TOGGLE = 2'b10,
      MODE_ROTATE = 2'b11
   } mode_t;

   mode_t                               mode_sel;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
   logic [WIDTH-1:0]                    din_s;
   logic [WIDTH-1:0]                    din_p;
   logic [WIDTH-1:0]                    din_rise;
   logic [WIDTH-1:0]                    dout;
   logic [WIDTH-1:0]                    dout_rot;
   logic [WIDTH-1:0]                    dout_next;
   logic                                changed_next;

   assign mode_sel = mode_t'(mode);

   // Synchroniser chain. io_in is asynchronous to clk, so it passes through
   // SYNC_STAGES flops before any logic looks at it. Reset clears every stage.
   // Data that is in flight when reset arrives is therefore thrown away rather
   // than leaking out after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= io_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign din_s = sync_q[SYNC_STAGES-1];

   // Edge-history register for TOGGLE. It follows din_s on every edge,
   // whatever the state of en, load and mode. Edges seen during a hold are
   // therefore absorbed and not replayed. Switching into TOGGLE also never
   // treats a level that is already high as a fresh edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_p <= '0;
      end else begin
         din_p <= din_s;
      end
   end

   assign din_rise = din_s & ~din_p;

   // Rotate-left-by-one. A single-bit bus has nothing to rotate, so in that
   // case the value simply recirculates.
   generate
      if (WIDTH == 1) begin : g_rot_narrow
         assign dout_rot = dout;
      end else begin : g_rot_wide
         assign dout_rot = {dout[WIDTH-2:0], dout[WIDTH-1]};
      end
   endgenerate

   // Next output value. load beats everything, including en=0. Otherwise
   // en=0 holds, and with en=1 the mode selects the transform. changed is
   // computed from the same next value, so it rises in the very cycle in which
   // the new io_out becomes visible.
   always_comb begin
      dout_next = dout;
      if (load) begin
         dout_next = din_s;
      end else if (en) begin
         case (mode_sel)
            MODE_INVERT: dout_next = ~din_s;
            MODE_PASS:   dout_next = din_s;
            MODE_TOGGLE: dout_next = dout ^ din_rise;
            MODE_ROTATE: dout_next = dout_rot;
            default:     dout_next = dout;
         endcase
      end
      changed_next = |(dout_next ^ dout);
   end

   // Output register and change flag. Both are plain flops, so there is no
   // combinational path from any input pin to io_out or changed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout    <= RESET_VAL;
         changed <= 1'b0;
      end else begin
         dout    <= dout_next;
         changed <= changed_next;
      end
   end

   assign io_out = dout;

endmodule

// File: tb/tb_reg_invert_bank.sv
// Testbench for reg_invert_bank. It drives an 8-bit, 2-stage instance through
// each feature, with checks against constants taken directly from the
// behavioural rules. A randomized run is then compared against an
// edge-indexed reference model. A 1-bit, 1-stage instance covers the
// narrow-bus corner cases.

module tb_reg_invert_bank;

   localparam int SYNC_A = 2;
   localparam logic [7:0] ROT_EXP [8] = '{8'h03, 8'h06, 8'h0C, 8'h18,
                                          8'h30, 8'h60, 8'hC0, 8'h81};

   logic       clk;
   logic       rst_n;
   logic [7:0] io_in;
   logic [1:0] mode;
   logic       en;
   logic       load;
   logic [7:0] out_a;
   logic       chg_a;

   logic       in_b;
   logic [1:0] mode_b;
   logic       en_b;
   logic       load_b;
   logic       out_b;
   logic       chg_b;

   int errors;
   int checks;

   logic [7:0] hist [8192];
   int         m_e;
   logic [7:0] m_dout;
   logic       m_chg;
   logic [7:0] m_ds;
   logic [7:0] m_dp;
   logic [7:0] m_nx;

   reg_invert_bank #(.WIDTH(8), .SYNC_STAGES(SYNC_A)) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_in   (io_in),
      .mode    (mode),
      .en      (en),
      .load    (load),
      .io_out  (out_a),
      .changed (chg_a)
   );

   reg_invert_bank #(.WIDTH(1), .SYNC_STAGES(1)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_in   (in_b),
      .mode    (mode_b),
      .en      (en_b),
      .load    (load_b),
      .io_out  (out_b),
      .changed (chg_b)
   );

   // Free-running clock with a 10-unit period. The first rising edge is at t=5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model for the 8-bit instance. Every sampled io_in is stored
   // under the index of the edge that sampled it. The synchronised value seen
   // at edge e is the sample from SYNC_A edges earlier. The edge-history value
   // is the sample from one edge before that. Anything before reset counts
   // as zero.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_e    = 0;
         m_dout = 8'hFF;
         m_chg  = 1'b0;
      end else begin
         m_ds = (m_e >= SYNC_A)     ? hist[m_e - SYNC_A]     : 8'h00;
         m_dp = (m_e >= SYNC_A + 1) ? hist[m_e - SYNC_A - 1] : 8'h00;
         hist[m_e] = io_in;
         if (load)
            m_nx = m_ds;
         else if (!en)
            m_nx = m_dout;
         else if (mode == 2'd0)
            m_nx = 8'hFF - m_ds;
         else if (mode == 2'd1)
            m_nx = m_ds;
         else if (mode == 2'd2)
            m_nx = m_dout ^ (m_ds & ~m_dp);
         else
            m_nx = 8'((m_dout * 2) % 256 + m_dout / 128);
         m_chg  = (m_nx != m_dout);
         m_dout = m_nx;
         if (m_e < 8191) m_e = m_e + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset value, behaviour while reset is held, and INVERT latency from pin to output.
   task automatic test_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_a !== 8'hFF) begin errors++; $display("[TB] FAIL reset_out: got %h want ff", out_a); end
      checks++;
      if (chg_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed: got %b want 0", chg_a); end
      mode  = 2'd0;
      en    = 1'b1;
      io_in = 8'h00;
      repeat (2) step();
      checks++;
      if (out_a !== 8'hFF || chg_a !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_held: got %h/%b want ff/0", out_a, chg_a);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (out_a !== 8'hFF || chg_a !== 1'b0) begin
            errors++; $display("[TB] FAIL invert_zero step%0d: got %h/%b want ff/0", k, out_a, chg_a);
         end
      end
      io_in = 8'hA5;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (out_a !== ((k >= 3) ? 8'h5A : 8'hFF)) begin
            errors++; $display("[TB] FAIL invert_latency edge%0d: got %h want %h", k, out_a, (k >= 3) ? 8'h5A : 8'hFF);
         end
         checks++;
         if (chg_a !== (k == 3)) begin
            errors++; $display("[TB] FAIL invert_changed edge%0d: got %b want %b", k, chg_a, k == 3);
         end
      end
   endtask

   // PASS with a hold: en=0 freezes the output. Re-enabling it picks up the new input.
   task automatic test_pass_hold();
      bit got;
      mode  = 2'd1;
      io_in = 8'h3C;
      repeat (4) step();
      checks++;
      if (out_a !== 8'h3C) begin errors++; $display("[TB] FAIL pass_settle: got %h want 3c", out_a); end
      en    = 1'b0;
      io_in = 8'hC3;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (out_a !== 8'h3C || chg_a !== 1'b0) begin
            errors++; $display("[TB] FAIL hold step%0d: got %h/%b want 3c/0", k, out_a, chg_a);
         end
      end
      en  = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 3 && !got; k++) begin
         step();
         if (out_a === 8'hC3) got = 1'b1;
      end
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL pass_resume: got %h want c3 within 3 edges", out_a); end
      checks++;
      if (chg_a !== 1'b1) begin errors++; $display("[TB] FAIL pass_resume_changed: got %b want 1", chg_a); end
   endtask

   // TOGGLE: two 4-cycle pulses on bit 0 give exactly two flips. Each flip
   // lands on the third edge after the rising input.
   task automatic test_toggle();
      bit hi;
      bit exp0;
      io_in = 8'h00;
      load  = 1'b1;
      repeat (3) step();
      checks++;
      if (out_a !== 8'h00) begin errors++; $display("[TB] FAIL toggle_preload: got %h want 00", out_a); end
      load = 1'b0;
      mode = 2'd2;
      for (int s = 1; s <= 20; s++) begin
         hi    = (s <= 4) || (s >= 9 && s <= 12);
         io_in = {7'b0, hi};
         step();
         exp0 = (s >= 3 && s < 11);
         checks++;
         if (out_a !== {7'b0, exp0}) begin
            errors++; $display("[TB] FAIL toggle step%0d: got %h want %h", s, out_a, {7'b0, exp0});
         end
         checks++;
         if (chg_a !== (s == 3 || s == 11)) begin
            errors++; $display("[TB] FAIL toggle_changed step%0d: got %b want %b", s, chg_a, s == 3 || s == 11);
         end
      end
   endtask

   // ROTATE from 81 walks one position per edge. Rotating all-ones never reports a change.
   task automatic test_rotate();
      io_in = 8'h81;
      load  = 1'b1;
      repeat (3) step();
      checks++;
      if (out_a !== 8'h81) begin errors++; $display("[TB] FAIL rotate_preload: got %h want 81", out_a); end
      load = 1'b0;
      mode = 2'd3;
      for (int k = 0; k < 8; k++) begin
         step();
         checks++;
         if (out_a !== ROT_EXP[k] || chg_a !== 1'b1) begin
            errors++; $display("[TB] FAIL rotate step%0d: got %h/%b want %h/1", k, out_a, chg_a, ROT_EXP[k]);
         end
      end
      io_in = 8'hFF;
      load  = 1'b1;
      repeat (3) step();
      load = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (out_a !== 8'hFF || chg_a !== 1'b0) begin
            errors++; $display("[TB] FAIL rotate_ones step%0d: got %h/%b want ff/0", k, out_a, chg_a);
         end
      end
   endtask

   // load wins over en and mode, and it still loads while en=0.
   task automatic test_priority();
      io_in = 8'h12;
      load  = 1'b1;
      en    = 1'b1;
      mode  = 2'd3;
      repeat (3) step();
      checks++;
      if (out_a !== 8'h12) begin errors++; $display("[TB] FAIL load_over_rotate: got %h want 12", out_a); end
      en    = 1'b0;
      io_in = 8'h34;
      repeat (3) step();
      checks++;
      if (out_a !== 8'h34) begin errors++; $display("[TB] FAIL load_while_hold: got %h want 34", out_a); end
      load = 1'b0;
   endtask

   // Reset asserted in the middle of a cycle acts without a clock edge. It
   // also flushes the synchroniser, so the first two outputs after release are zero.
   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_a !== 8'hFF || chg_a !== 1'b0) begin
         errors++; $display("[TB] FAIL async_reset: got %h/%b want ff/0", out_a, chg_a);
      end
      mode = 2'd1;
      en   = 1'b1;
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if (out_a !== ((k == 3) ? 8'h34 : 8'h00)) begin
            errors++; $display("[TB] FAIL reset_flush edge%0d: got %h want %h", k, out_a, (k == 3) ? 8'h34 : 8'h00);
         end
      end
   endtask

   // Narrow build: INVERT latency is two edges, and ROTATE recirculates the single bit.
   task automatic test_narrow();
      mode_b = 2'd0;
      en_b   = 1'b1;
      in_b   = 1'b0;
      repeat (2) step();
      checks++;
      if (out_b !== 1'b1) begin errors++; $display("[TB] FAIL narrow_idle: got %b want 1", out_b); end
      in_b = 1'b1;
      step();
      checks++;
      if (out_b !== 1'b1) begin errors++; $display("[TB] FAIL narrow_edge1: got %b want 1", out_b); end
      step();
      checks++;
      if (out_b !== 1'b0 || chg_b !== 1'b1) begin
         errors++; $display("[TB] FAIL narrow_edge2: got %b/%b want 0/1", out_b, chg_b);
      end
      mode_b = 2'd3;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_b !== 1'b0 || chg_b !== 1'b0) begin
            errors++; $display("[TB] FAIL narrow_rotate0 step%0d: got %b/%b want 0/0", k, out_b, chg_b);
         end
      end
      load_b = 1'b1;
      repeat (2) step();
      load_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_b !== 1'b1 || chg_b !== 1'b0) begin
            errors++; $display("[TB] FAIL narrow_rotate1 step%0d: got %b/%b want 1/0", k, out_b, chg_b);
         end
      end
      en_b = 1'b0;
   endtask

   // Randomized traffic on the 8-bit instance, compared edge by edge with the reference model.
   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) io_in = 8'($urandom);
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
         en   = ($urandom_range(0, 3) != 0);
         load = ($urandom_range(0, 11) == 0);
         step();
         checks++;
         if (out_a !== m_dout) begin
            errors++; $display("[TB] FAIL random_out step%0d: got %h want %h", k, out_a, m_dout);
         end
         checks++;
         if (chg_a !== m_chg) begin
            errors++; $display("[TB] FAIL random_changed step%0d: got %b want %b", k, chg_a, m_chg);
         end
      end
      load = 1'b0;
   endtask

   // Watchdog so that the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence.
   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b1;
      io_in  = 8'h00;
      mode   = 2'd0;
      en     = 1'b0;
      load   = 1'b0;
      in_b   = 1'b0;
      mode_b = 2'd0;
      en_b   = 1'b0;
      load_b = 1'b0;
      test_reset();
      test_pass_hold();
      test_toggle();
      test_rotate();
      test_priority();
      test_async_reset();
      test_narrow();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
